// File: rtl/alu_pkg.sv
// Shared types for the nibble-serial ALU: command encoding, core control bundle, widths.
`default_nettype none

package alu_pkg;

    localparam int NIBBLE_W = 4;
    localparam int WORD_W   = 32;

    typedef enum logic [2:0] {
        ADD   = 3'd0,
        SUB   = 3'd1,
        AND   = 3'd2,
        OR    = 3'd3,
        XOR   = 3'd4,
        LSHFT = 3'd5,
        RSHFT = 3'd6,
        ASR   = 3'd7
    } alu_cmd_e;

    typedef struct packed {
        alu_cmd_e cmd;
        logic     carry_in;
    } alu_ctrl_t;

endpackage

`default_nettype wire

// File: rtl/nibble_alu_core.sv
// Combinational 4-bit ALU slice; the carry input doubles as the shift link between nibbles.
`default_nettype none

module nibble_alu_core
    import alu_pkg::*;
(
    input  alu_ctrl_t             ctrl,
    input  logic [NIBBLE_W-1:0]   d1,
    input  logic [NIBBLE_W-1:0]   d2,
    output logic [NIBBLE_W-1:0]   res,
    output logic                  carry_out
);

    logic [NIBBLE_W:0] sum;

    always_comb begin
        sum       = '0;
        res       = '0;
        carry_out = ctrl.carry_in;
        case (ctrl.cmd)
            ADD: begin
                sum       = {1'b0, d1} + {1'b0, d2} + {{NIBBLE_W{1'b0}}, ctrl.carry_in};
                res       = sum[NIBBLE_W-1:0];
                carry_out = sum[NIBBLE_W];
            end
            SUB: begin
                sum       = {1'b0, d1} + {1'b0, ~d2} + {{NIBBLE_W{1'b0}}, ctrl.carry_in};
                res       = sum[NIBBLE_W-1:0];
                carry_out = sum[NIBBLE_W];
            end
            AND: res = d1 & d2;
            OR:  res = d1 | d2;
            XOR: res = d1 ^ d2;
            LSHFT: begin
                res       = {d2[NIBBLE_W-2:0], ctrl.carry_in};
                carry_out = d2[NIBBLE_W-1];
            end
            // Right shifts share one path; the sign fill for ASR comes in via the seeded carry.
            RSHFT, ASR: begin
                res       = {ctrl.carry_in, d2[NIBBLE_W-1:1]};
                carry_out = d2[0];
            end
            default: res = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/nibble_serial_alu.sv
// Nibble-serial 32-bit ALU: one 4-bit slice per clock, 8 clocks per operation.
// Optional feature macro: NIBBLE_ALU_ASR_EN (cmd 7 = arithmetic right shift).
`default_nettype none

module nibble_serial_alu
    import alu_pkg::*;
#(
    parameter int NIBBLES = 8
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        cmd,
    input  logic [WORD_W-1:0] word1,
    input  logic [WORD_W-1:0] word2,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] result,
    output logic              carry_out
);

    localparam logic [2:0] LAST_IDX = 3'(NIBBLES - 1);

    logic [WORD_W-1:0]   a_q;
    logic [WORD_W-1:0]   b_q;
    alu_cmd_e            cmd_q;
    logic                carry_q;
    logic [2:0]          idx_q;

    alu_cmd_e            start_cmd;
    logic                start_carry;
    logic                start_msb_first;
    logic                msb_first;
    logic                last_nibble;
    logic [4:0]          bit_base;
    logic [NIBBLE_W-1:0] d1;
    logic [NIBBLE_W-1:0] d2;
    logic [NIBBLE_W-1:0] core_res;
    logic                core_co;
    alu_ctrl_t           ctrl;

    // Decode the incoming command and seed the carry link for the first slice.
    always_comb begin
        start_cmd = alu_cmd_e'(cmd);
`ifdef NIBBLE_ALU_ASR_EN
        if (start_cmd == SUB)
            start_carry = 1'b1;
        else if (start_cmd == ASR)
            start_carry = word2[WORD_W-1];
        else
            start_carry = 1'b0;
`else
        if (start_cmd == ASR)
            start_cmd = RSHFT;
        start_carry = (start_cmd == SUB);
`endif
    end

    assign start_msb_first = (start_cmd == RSHFT) || (start_cmd == ASR);
    assign msb_first       = (cmd_q == RSHFT) || (cmd_q == ASR);
    assign last_nibble     = msb_first ? (idx_q == 3'd0) : (idx_q == LAST_IDX);

    assign bit_base = {idx_q, 2'b00};
    assign d1       = a_q[bit_base +: NIBBLE_W];
    assign d2       = b_q[bit_base +: NIBBLE_W];
    assign ctrl     = '{cmd: cmd_q, carry_in: carry_q};

    nibble_alu_core u_core (
        .ctrl      (ctrl),
        .d1        (d1),
        .d2        (d2),
        .res       (core_res),
        .carry_out (core_co)
    );

    assign carry_out = carry_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q     <= '0;
            b_q     <= '0;
            cmd_q   <= ADD;
            carry_q <= 1'b0;
            idx_q   <= 3'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                if (start) begin
                    a_q     <= word1;
                    b_q     <= word2;
                    cmd_q   <= start_cmd;
                    carry_q <= start_carry;
                    idx_q   <= start_msb_first ? LAST_IDX : 3'd0;
                    busy    <= 1'b1;
                    result  <= '0;
                end
            end else begin
                result[bit_base +: NIBBLE_W] <= core_res;
                carry_q <= core_co;
                idx_q   <= msb_first ? (idx_q - 3'd1) : (idx_q + 3'd1);
                if (last_nibble) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_alu.sv
// Scoreboard bench for nibble_serial_alu: word-level reference model, queue of expected results.
`default_nettype none

module tb_nibble_serial_alu;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  cmd = 3'd0;
    logic [31:0] word1 = '0;
    logic [31:0] word2 = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        carry_out;

    always #5 clk = ~clk;

    nibble_serial_alu #(.NIBBLES(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .cmd       (cmd),
        .word1     (word1),
        .word2     (word2),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out)
    );

    typedef struct {
        logic [31:0] r;
        logic        co;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    // Word-level reference: {carry_out, result}
    function automatic logic [32:0] model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        case (c)
            3'd0: s = {1'b0, a} + {1'b0, b};
            3'd1: s = {1'b0, a} + {1'b0, ~b} + 33'd1;
            3'd2: s = {1'b0, a & b};
            3'd3: s = {1'b0, a | b};
            3'd4: s = {1'b0, a ^ b};
            3'd5: s = {b[31], b[30:0], 1'b0};
            3'd6: s = {b[0], 1'b0, b[31:1]};
`ifdef NIBBLE_ALU_ASR_EN
            default: s = {b[0], b[31], b[31:1]};
`else
            default: s = {b[0], 1'b0, b[31:1]};
`endif
        endcase
        return s;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset && done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 64'(done), 64'(0));
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result", 64'(result), 64'(e.r));
                chk("carry_out", 64'(carry_out), 64'(e.co));
                chk("done_latency", 64'(cyc), 64'(e.cyc));
                chk("busy_at_done", 64'(busy), 64'(0));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 64'(busy), 64'(0));
    endtask

    task automatic issue(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [32:0] m;
        wait_idle();
        m     = model(c, a, b);
        e.r   = m[31:0];
        e.co  = m[32];
        e.cyc = cyc + 9;
        q.push_back(e);
        cmd   = c;
        word1 = a;
        word2 = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'(1));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_result", 64'(result), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_carry", 64'(carry_out), 64'(0));
        reset = 1'b1;
        @(negedge clk);

        issue(3'd0, 32'hEFFF_FFFF, 32'h0000_0001);
        issue(3'd0, 32'hFFFF_0FFF, 32'h0000_0002);
        issue(3'd0, 32'hFFFF_FFFF, 32'h0000_0001);
        issue(3'd1, 32'h0000_0005, 32'h0000_0007);
        issue(3'd1, 32'h0000_0007, 32'h0000_0005);
        issue(3'd6, 32'h1234_5678, 32'h0600_0000);
        issue(3'd5, 32'hDEAD_BEEF, 32'h8000_0001);
        issue(3'd7, 32'h0000_0000, 32'h8000_0000);
        issue(3'd7, 32'h0000_0000, 32'h8000_0003);

        // Start while busy must be ignored.
        issue(3'd0, 32'h0000_0001, 32'h0000_0002);
        @(negedge clk);
        cmd   = 3'd1;
        word1 = 32'hFFFF_FFFF;
        word2 = 32'h1111_1111;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        // Back-to-back: next start issued in the done cycle.
        wait_idle();
        chk("b2b_done_cycle", 64'(done), 64'(1));
        issue(3'd4, 32'hA5A5_A5A5, 32'h0F0F_F0F0);
        wait_idle();
        chk("b2b_done_cycle2", 64'(done), 64'(1));
        issue(3'd2, 32'hFF00_FF00, 32'h0FF0_0FF0);

        // Reset in the middle of an XOR aborts it with no done pulse.
        issue(3'd4, 32'h1234_5678, 32'h0F0F_0F0F);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_result", 64'(result), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        chk("abort_carry", 64'(carry_out), 64'(0));
        void'(q.pop_back());
        @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        chk("post_abort_busy", 64'(busy), 64'(0));

        for (int i = 0; i < 40; i++) begin
            issue(3'($urandom_range(0, 7)), $urandom, $urandom);
            if ($urandom_range(0, 3) == 0)
                repeat ($urandom_range(9, 14)) @(negedge clk);
        end

        begin
            int n = 0;
            while (q.size() != 0 && n < 200) begin
                @(negedge clk);
                n++;
            end
        end
        @(negedge clk);
        chk("queue_drained", 64'(q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
